// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes sclk/lrclk/sdata into clk_i and assembles 16-bit left/right samples.
// Defining I2S_RX_WATCHDOG_EN adds an sclk-loss watchdog that drops lock after WD_CYCLES idle clocks.
module i2s_rx #(
  parameter int unsigned WD_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        sclk,
  input  logic        lrclk,
  input  logic        sdata,
  output logic [15:0] left_chan,
  output logic [15:0] right_chan,
  output logic        sample_valid,
  output logic        locked
);

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } state_e;

  state_e      state_q;
  logic [2:0]  sclk_sync_q;
  logic [1:0]  lrclk_sync_q;
  logic [1:0]  sdata_sync_q;
  logic        lrclk_prev_q;
  logic        prev_valid_q;
  logic [15:0] word_q;
  logic [4:0]  n_q;
  logic [15:0] stage_q;
  logic        stage_valid_q;
  logic [15:0] left_q;
  logic [15:0] right_q;
  logic        valid_q;
  logic        locked_q;

  logic        rise;
  logic        lr_s;
  logic        sd_s;
  logic        lr_change;
  logic        wd_trip;
  logic [15:0] word_d;
  logic [4:0]  n_d;

  assign rise      = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign lr_s      = lrclk_sync_q[1];
  assign sd_s      = sdata_sync_q[1];
  // no change is reported until one lrclk value has been seen since reset/trip
  assign lr_change = prev_valid_q && (lr_s != lrclk_prev_q);

  // word with the current sdata bit captured; saturates once 16 bits are held
  always_comb begin
    word_d = word_q;
    n_d    = n_q;
    if (n_q < 5'd16) begin
      word_d[4'd15 - n_q[3:0]] = sd_s;
      n_d = n_q + 5'd1;
    end
  end

  if (WD_CYCLES < 2) begin : g_wd_range
    $error("i2s_rx: WD_CYCLES must be at least 2");
  end

`ifdef I2S_RX_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;

  assign wd_trip = !rise && (wd_cnt_q == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      wd_cnt_q <= '0;
    end else if (rise || wd_trip) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end
`else
  assign wd_trip = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q       <= ST_UNSYNC;
      sclk_sync_q   <= '0;
      lrclk_sync_q  <= '0;
      sdata_sync_q  <= '0;
      lrclk_prev_q  <= 1'b0;
      prev_valid_q  <= 1'b0;
      word_q        <= '0;
      n_q           <= '0;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[1:0], sclk};
      lrclk_sync_q <= {lrclk_sync_q[0], lrclk};
      sdata_sync_q <= {sdata_sync_q[0], sdata};
      valid_q      <= 1'b0;

      if (wd_trip) begin
        state_q       <= ST_UNSYNC;
        prev_valid_q  <= 1'b0;
        word_q        <= '0;
        n_q           <= '0;
        stage_valid_q <= 1'b0;
        left_q        <= '0;
        right_q       <= '0;
        locked_q      <= 1'b0;
      end else if (rise) begin
        lrclk_prev_q <= lr_s;
        prev_valid_q <= 1'b1;
        if (lr_change) begin
          // the bit on the change rise is the LSB of the outgoing word (one-bit delay)
          word_q <= '0;
          n_q    <= '0;
          if (state_q == ST_UNSYNC) begin
            state_q <= ST_SYNC;
          end else if (!lrclk_prev_q) begin
            stage_q       <= word_d;
            stage_valid_q <= 1'b1;
          end else begin
            stage_valid_q <= 1'b0;
            if (stage_valid_q) begin
              left_q   <= stage_q;
              right_q  <= word_d;
              valid_q  <= 1'b1;
              locked_q <= 1'b1;
            end
          end
        end else begin
          word_q <= word_d;
          n_q    <= n_d;
        end
      end
    end
  end

  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter: WD_CYCLES, default 4096, clk_i cycles without an sclk rising edge before the watchdog trips (used only when I2S_RX_WATCHDOG_EN is defined).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk_i and res_n_i.
REQ-003 clk_i  input  1  system clock; sclk frequency SHALL be at most clk_i/4.
REQ-004 res_n_i  input  1  asynchronous active-low reset.
REQ-005 sclk  input  1  I2S bit clock, asynchronous to clk_i.
REQ-006 lrclk  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
REQ-007 sdata  input  1  I2S serial data, MSB first, two's complement.
REQ-008 left_chan  output  16  last complete left sample.
REQ-009 right_chan  output  16  last complete right sample.
REQ-010 sample_valid  output  1  one-clk_i pulse when a left/right pair is updated.
REQ-011 locked  output  1  high once a full frame has been received since reset or watchdog trip.

Function
REQ-012 sclk, lrclk and sdata SHALL each pass through a 2-flop synchronizer; the sclk rising edge SHALL be detected from synchronized sclk against a third delay flop.
REQ-013 All sampling SHALL occur only on detected sclk rising edges ("rise"); lrclk_prev SHALL hold lrclk as sampled at the previous rise.
REQ-014 Bit capture on each rise with unchanged lrclk: if bit count n<16, word[15-n] <= sdata and n++; if n=16, the bit is discarded and n saturates.
REQ-015 Words shorter than 16 bits SHALL be left-aligned with zero LSBs; bits beyond 16 SHALL be discarded.
REQ-016 lrclk change rise (I2S one-bit delay): the sdata bit on that rise SHALL be captured by the REQ-014 rule as the last bit of the outgoing word, the word SHALL then be committed to the channel given by lrclk_prev, and word and n SHALL be cleared.
REQ-017 Left commit (lrclk_prev=0) SHALL load a staging register only; no output change.
REQ-018 Right commit (lrclk_prev=1) with a valid staged left SHALL load left_chan from staging and right_chan from the committed word and pulse sample_valid for one cycle, both simultaneously.
REQ-019 Latency: sample_valid SHALL rise exactly 3 clk_i rising edges after the pin-level sclk rise on which the lrclk 1->0 change is present.
REQ-020 States: UNSYNC (after reset) -> first lrclk change discards the partial word -> SYNC; left staging valid SHALL be set only by a left commit in SYNC and cleared after each right commit.
REQ-021 locked SHALL be set with the first sample_valid and SHALL hold until reset or watchdog trip.
REQ-022 A right commit without a staged left (frame begun mid-right) SHALL be discarded and produce no pulse.

Reset
REQ-023 While res_n_i=0: left_chan=0, right_chan=0, sample_valid=0, locked=0; synchronizers, word, n, staging and state cleared to UNSYNC.
REQ-024 Reset assertion mid-word SHALL abort the word; the first frame after release SHALL be resynchronized per REQ-020.

Configuration
REQ-025 With I2S_RX_WATCHDOG_EN defined: a counter SHALL reset on every rise, and on reaching WD_CYCLES SHALL zero left_chan/right_chan, clear locked and staging, and return to UNSYNC; without the macro, no counter exists and outputs hold indefinitely when sclk stops.

Verification
REQ-026 Left 0x1234, right 0xABCD, 32 sclk/frame, clk_i:sclk = 8:1 -> one sample_valid, left_chan=0x1234, right_chan=0xABCD, locked=1.
REQ-027 24-bit words, left 0x7FFFFF, right 0x800001 -> left_chan=0x7FFF, right_chan=0x8000.
REQ-028 12-bit words, left 0xABC, right 0x123 -> left_chan=0xABC0, right_chan=0x1230.
REQ-029 Stream started with lrclk=1 mid-word -> first right word discarded, no pulse until one full left+right pair is received.
REQ-030 res_n_i pulsed low during a left word -> outputs 0 immediately, locked=0; next full frame 0x0001/0xFFFF -> left_chan=0x0001, right_chan=0xFFFF.
REQ-031 I2S_RX_WATCHDOG_EN with WD_CYCLES=64: sclk stopped after valid frame -> on cycle 64, outputs 0, locked=0; without the macro, outputs hold.
